// File: rtl/flash_prog_sched.sv
// flash_prog_sched: WREN/SE/RDSR/PP command scheduler for one SPI flash bus.
// Define FLASH_ERASE_EN to include the WREN/SE/RDSR erase phase.
module flash_prog_sched #(
    parameter int          CS_GAP   = 8,
    parameter logic [15:0] POLL_MAX = 16'd60000,
    parameter logic [7:0]  CMD_WREN = 8'h06,
`ifdef FLASH_ERASE_EN
    parameter logic [7:0]  CMD_SE   = 8'hD8,
`endif
    parameter logic [7:0]  CMD_PP   = 8'h02,
    parameter logic [7:0]  CMD_RDSR = 8'h05
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        data_req,
    input  logic [7:0]  data_in,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [7:0] GAP_LIM = 8'(CS_GAP);

    typedef enum logic [3:0] {
        IDLE,
`ifdef FLASH_ERASE_EN
        WREN1,
        SE,
        POLL1,
`endif
        WREN2,
        PP,
        POLL2,
        DONE,
        ERR
    } state_t;

`ifdef FLASH_ERASE_EN
    localparam state_t FIRST = WREN1;
`else
    localparam state_t FIRST = WREN2;
`endif

    state_t      state, state_nx;
    logic        armed;
    logic        run;
    logic [1:0]  ph;
    logic [2:0]  bit_cnt;
    logic [8:0]  byte_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  tx_sh;
    logic        rx_bit;
    logic [7:0]  data_buf;
    logic [1:0]  req_pipe;
    logic [15:0] poll_cnt;
    logic [23:0] addr_r;
    logic [7:0]  len_r;

    logic        is_cmd, is_poll;
    logic [7:0]  first_byte, next_byte;
    logic [8:0]  last_idx, nb;
    logic        launch, byte_end, stat_byte;
    logic        stat_ok, stat_to, cmd_end, abort, req_win;
    logic        accept;

    // Per-state command shape: opcode, length, whether it is a status poll
    always_comb begin
        is_cmd     = 1'b0;
        is_poll    = 1'b0;
        first_byte = CMD_WREN;
        last_idx   = 9'd0;
        case (state)
`ifdef FLASH_ERASE_EN
            WREN1: is_cmd = 1'b1;
            SE: begin
                is_cmd     = 1'b1;
                first_byte = CMD_SE;
                last_idx   = 9'd3;
            end
            POLL1: begin
                is_cmd     = 1'b1;
                is_poll    = 1'b1;
                first_byte = CMD_RDSR;
            end
`endif
            WREN2: is_cmd = 1'b1;
            PP: begin
                is_cmd     = 1'b1;
                first_byte = CMD_PP;
                last_idx   = 9'd4 + {1'b0, len_r};
            end
            POLL2: begin
                is_cmd     = 1'b1;
                is_poll    = 1'b1;
                first_byte = CMD_RDSR;
            end
            default: ;
        endcase
    end

    // Byte to load at the next boundary; status reads shift out zeros
    always_comb begin
        nb        = byte_cnt + 9'd1;
        next_byte = 8'h00;
        if (!is_poll) begin
            case (nb)
                9'd1:    next_byte = addr_r[23:16];
                9'd2:    next_byte = addr_r[15:8];
                9'd3:    next_byte = addr_r[7:0];
                default: next_byte = data_buf;
            endcase
        end
    end

    // Command framing and poll exit conditions
    always_comb begin
        accept    = (state == IDLE) && start && armed;
        launch    = is_cmd && !run && (gap_cnt >= GAP_LIM);
        byte_end  = run && (ph == 2'd3) && (bit_cnt == 3'd7);
        stat_byte = is_poll && (byte_cnt != 9'd0);
        stat_ok   = stat_byte && !rx_bit;
        stat_to   = stat_byte && rx_bit &&
                    ((poll_cnt + 16'd1) >= POLL_MAX);
        cmd_end   = byte_end &&
                    (is_poll ? stat_ok : (byte_cnt == last_idx));
        abort     = byte_end && stat_to;
        req_win   = (state == PP) && (byte_cnt >= 9'd3) &&
                    (byte_cnt <= 9'd3 + {1'b0, len_r});
    end

    // Sequencer state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    // Next-state and status pulses
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_nx = FIRST;
            end
`ifdef FLASH_ERASE_EN
            WREN1: if (cmd_end) state_nx = SE;
            SE:    if (cmd_end) state_nx = POLL1;
            POLL1: begin
                if (cmd_end)    state_nx = WREN2;
                else if (abort) state_nx = ERR;
            end
`endif
            WREN2: if (cmd_end) state_nx = PP;
            PP:    if (cmd_end) state_nx = POLL2;
            POLL2: begin
                if (cmd_end)    state_nx = DONE;
                else if (abort) state_nx = ERR;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                busy     = 1'b0;
                err      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // SPI bit engine, chip-select gap timer and program-data fetch
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            armed    <= 1'b0;
            run      <= 1'b0;
            ph       <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 9'd0;
            gap_cnt  <= 8'd0;
            tx_sh    <= 8'h00;
            rx_bit   <= 1'b0;
            data_buf <= 8'h00;
            req_pipe <= 2'b00;
            poll_cnt <= 16'd0;
            addr_r   <= 24'd0;
            len_r    <= 8'd0;
            data_req <= 1'b0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            armed    <= 1'b1;
            data_req <= 1'b0;
            req_pipe <= {req_pipe[0], data_req};
            if (req_pipe[1]) data_buf <= data_in;
            if (!cs_n)                gap_cnt <= 8'd0;
            else if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;
            if (accept) begin
                addr_r <= addr;
                len_r  <= len;
            end
            if (launch) begin
                cs_n     <= 1'b0;
                run      <= 1'b1;
                ph       <= 2'd0;
                bit_cnt  <= 3'd0;
                byte_cnt <= 9'd0;
                poll_cnt <= 16'd0;
                tx_sh    <= first_byte;
            end else if (run) begin
                ph <= ph + 2'd1;
                case (ph)
                    2'd0: begin
                        sck   <= 1'b0;
                        mosi  <= tx_sh[7];
                        tx_sh <= {tx_sh[6:0], 1'b0};
                        if (bit_cnt == 3'd0 && req_win) data_req <= 1'b1;
                    end
                    2'd2: begin
                        sck    <= 1'b1;
                        rx_bit <= miso;
                    end
                    2'd3: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (cmd_end || abort) begin
                                run  <= 1'b0;
                                cs_n <= 1'b1;
                                sck  <= 1'b0;
                                mosi <= 1'b0;
                            end else begin
                                byte_cnt <= byte_cnt + 9'd1;
                                tx_sh    <= next_byte;
                                if (stat_byte) poll_cnt <= poll_cnt + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_prog_sched.sv
// tb_flash_prog_sched: directed vectors against an SPI flash slave model.
// Follows FLASH_ERASE_EN to pick the expected command stream.
module tb_flash_prog_sched;

    localparam int          CS_GAP   = 8;
    localparam logic [15:0] POLL_MAX = 16'd20;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = 24'd0;
    logic [7:0]  len = 8'd0;
    logic [7:0]  data_in = 8'd0;
    logic        miso = 1'b0;
    logic        data_req, sck, cs_n, mosi, busy, done, err;

    flash_prog_sched #(
        .CS_GAP   (CS_GAP),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .addr      (addr),
        .len       (len),
        .data_req  (data_req),
        .data_in   (data_in),
        .miso      (miso),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        logic [7:0]  seed;
        int          wip_se;
        int          wip_pp;
        bit          exp_err;
    } vec_t;

    vec_t vt[4];

    int n_tests = 0;
    int n_fail  = 0;

    // bench-owned stimulus knobs read by the flash model
    int         wip_a = 0;
    int         wip_b = 0;
    logic [7:0] seed = 8'd0;
    int         d_base = 0;
    int         rdsr_base = 0;

    // flash model state, written only by the model process
    int         f_bits = 0;
    int         lo_cyc = 0;
    int         hi_cyc = 1000;
    int         gap_bad = 0;
    int         tim_bad = 0;
    int         mosi_bad = 0;
    int         n_rdsr = 0;
    int         last_stat = 0;
    int         nreq = 0;
    int         ndone = 0;
    int         nerr = 0;
    int         didx = 0;
    logic [7:0] f_sh = 8'd0;
    logic [7:0] f_op = 8'd0;
    logic       cs_p = 1'b1;
    logic       sck_p = 1'b0;
    logic       rq1 = 1'b0;
    logic [7:0] mq[$];

    // SPI mode-0 flash slave, data FIFO and event counters, sampled mid-cycle
    always @(negedge sys_clk) begin
        int         sn;
        int         k;
        int         wip;
        logic [7:0] st;
        if (cs_p && !cs_n) begin
            if (hi_cyc < CS_GAP) gap_bad++;
            f_bits = 0;
            lo_cyc = 0;
        end
        if (!cs_p && cs_n) begin
            if ((f_bits % 8) != 0 || lo_cyc != 32 * (f_bits / 8)) tim_bad++;
            if (f_op == 8'h05) begin
                last_stat = f_bits / 8 - 1;
                n_rdsr++;
            end
            f_op = 8'h00;
            hi_cyc = 0;
        end
        if (!sck_p && sck) begin
            if (cs_n) tim_bad++;
            else begin
                f_sh = {f_sh[6:0], mosi};
                f_bits++;
                if ((f_bits % 8) == 0) begin
                    if (f_bits == 8) begin
                        f_op = f_sh;
                        mq.push_back(f_sh);
                    end else if (f_op == 8'h05) begin
                        if (f_sh != 8'h00) mosi_bad++;
                    end else begin
                        mq.push_back(f_sh);
                    end
                end
            end
        end
        if (sck_p && !sck && !cs_n && f_op == 8'h05 && f_bits >= 8) begin
            sn = f_bits / 8 - 1;
            k = f_bits % 8;
`ifdef FLASH_ERASE_EN
            wip = (n_rdsr == rdsr_base) ? wip_a : wip_b;
`else
            wip = wip_b;
`endif
            st = (sn < wip) ? 8'h03 : 8'h02;
            miso = st[7-k];
        end
        if (rq1) begin
            data_in = seed + 8'(didx - d_base);
            didx++;
        end
        rq1 = data_req;
        if (data_req) nreq++;
        if (done) ndone++;
        if (err) nerr++;
        if (!cs_n) lo_cyc++;
        else       hi_cyc++;
        cs_p = cs_n;
        sck_p = sck;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        logic [7:0] exp[$];
        int  qb, b_req, b_done, b_err, b_gap, b_tim, b_mb;
        int  cyc, bad, n;
        bit  erase_to;
        string t;
        t = $sformatf("v%0d", id);
        erase_to = 1'b0;
`ifdef FLASH_ERASE_EN
        erase_to = v.exp_err;
        exp.push_back(8'h06);
        exp.push_back(8'hD8);
        exp.push_back(v.addr[23:16]);
        exp.push_back(v.addr[15:8]);
        exp.push_back(v.addr[7:0]);
        exp.push_back(8'h05);
`endif
        if (!erase_to) begin
            exp.push_back(8'h06);
            exp.push_back(8'h02);
            exp.push_back(v.addr[23:16]);
            exp.push_back(v.addr[15:8]);
            exp.push_back(v.addr[7:0]);
            for (int j = 0; j <= int'(v.len); j++)
                exp.push_back(v.seed + 8'(j));
            exp.push_back(8'h05);
        end
        wip_a = v.wip_se;
        wip_b = v.wip_pp;
        seed = v.seed;
        d_base = didx;
        rdsr_base = n_rdsr;
        qb = mq.size();
        b_req = nreq;
        b_done = ndone;
        b_err = nerr;
        b_gap = gap_bad;
        b_tim = tim_bad;
        b_mb = mosi_bad;
        @(negedge sys_clk);
        start = 1'b1;
        addr = v.addr;
        len = v.len;
        @(negedge sys_clk);
        start = 1'b0;
        chk({t, " busy_on"}, int'(busy), 1);
        cyc = 0;
        while ((ndone + nerr) == (b_done + b_err) && cyc < 40000) begin
            @(negedge sys_clk);
            cyc++;
            if (cyc == 150 && busy) begin
                start = 1'b1;
                addr = 24'hFFFFFF;
                len = 8'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({t, " finished"}, int'(cyc < 40000), 1);
        repeat (2) @(negedge sys_clk);
        chk({t, " done_cnt"}, ndone - b_done, v.exp_err ? 0 : 1);
        chk({t, " err_cnt"}, nerr - b_err, v.exp_err ? 1 : 0);
        chk({t, " busy_off"}, int'(busy), 0);
        chk({t, " cs_idle"}, int'(cs_n), 1);
        chk({t, " data_req"}, nreq - b_req, erase_to ? 0 : int'(v.len) + 1);
        chk({t, " stat_bytes"}, last_stat,
            v.exp_err ? int'(POLL_MAX) : v.wip_pp + 1);
        n = mq.size() - qb;
        chk({t, " stream_len"}, n, exp.size());
        bad = 0;
        for (int i = 0; i < n && i < exp.size(); i++)
            if (mq[qb+i] != exp[i]) bad++;
        chk({t, " stream_bytes_bad"}, bad, 0);
        chk({t, " cs_gap_bad"}, gap_bad - b_gap, 0);
        chk({t, " byte_timing_bad"}, tim_bad - b_tim, 0);
        chk({t, " status_mosi_bad"}, mosi_bad - b_mb, 0);
    endtask

    initial begin
        int qb, cyc, hdr;
        vt[0] = '{24'h000425, 8'd9,   8'h10, 3,    2,    1'b0};
        vt[1] = '{24'h123400, 8'd0,   8'hA5, 1,    0,    1'b0};
        vt[2] = '{24'hABCD00, 8'd255, 8'h00, 0,    4,    1'b0};
        vt[3] = '{24'h000100, 8'd5,   8'h40, 1000, 1000, 1'b1};

        repeat (3) @(negedge sys_clk);
        chk("reset_outputs",
            int'({sck, cs_n, mosi, data_req, busy, done, err}), 7'b0100000);

        start = 1'b1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("start_at_reset_release", int'({busy, cs_n}), 2'b01);

        for (int i = 0; i < 4; i++) run_vec(i, vt[i]);

`ifdef FLASH_ERASE_EN
        hdr = 11;
`else
        hdr = 5;
`endif
        wip_a = vt[0].wip_se;
        wip_b = vt[0].wip_pp;
        seed = vt[0].seed;
        d_base = didx;
        rdsr_base = n_rdsr;
        qb = mq.size();
        @(negedge sys_clk);
        start = 1'b1;
        addr = vt[0].addr;
        len = vt[0].len;
        @(negedge sys_clk);
        start = 1'b0;
        cyc = 0;
        while (mq.size() < qb + hdr + 3 && cyc < 20000) begin
            @(negedge sys_clk);
            cyc++;
        end
        chk("reach_data_byte3", int'(cyc < 20000), 1);
        repeat (10) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_outputs", int'({cs_n, sck, busy, data_req}), 4'b1000);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        run_vec(4, vt[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_prog_sched.md
Name: flash_prog_sched

Overview:
- Command scheduler for the single SPI flash bus (M25P16-class device, SPI mode 0).
- On one start pulse, runs the full sequence: WREN → SE (sector erase) → RDSR poll until WIP=0 → WREN → PP (page program) of 1..256 bytes → RDSR poll → done.
- Program data is pulled from an upstream FIFO through a request/data interface.
- Sits beside the flash read controller; top level muxes the SPI pins by `busy`.

Parameters:
- CS_GAP, 8: minimum sys_clk cycles cs_n held high between consecutive commands.
- POLL_MAX, 16'd60000: maximum status bytes read in one RDSR poll before timeout.
- CMD_WREN, 8'h06: write enable opcode.
- CMD_SE, 8'hD8: sector erase opcode.
- CMD_PP, 8'h02: page program opcode.
- CMD_RDSR, 8'h05: read status register opcode.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse; begins the sequence. Ignored while busy=1.
- addr, input, 24: start address, captured on start. SE uses the same 24-bit address.
- len, input, 8: byte count minus 1 (0 → 1 byte, 255 → 256 bytes), captured on start.
- data_req, output, 1: one-cycle pulse requesting the next program byte.
- data_in, input, 8: program byte, valid exactly 2 cycles after data_req.
- miso, input, 1: flash serial out.
- sck, output, 1: SPI clock, sys_clk/4.
- cs_n, output, 1: flash chip select, active low.
- mosi, output, 1: flash serial in, MSB first.
- busy, output, 1: high from the cycle after an accepted start until done/err.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: one-cycle pulse on poll timeout.

Behaviour:
- Reset values: sck=0, cs_n=1, mosi=0, data_req=0, busy=0, done=0, err=0; state=IDLE. Reset asserted mid-operation aborts immediately; there is no resume.
- Bit timing:
  - 2-bit phase counter runs while cs_n=0.
  - Phase 0: sck←0 and mosi updates.
  - Phase 2: sck←1.
  - miso shifted in on the cycle sck rises.
  - One bit = 4 cycles; one byte = 32 cycles.
- cs_n timing:
  - cs_n falls 1 cycle before phase 0 of the first bit.
  - cs_n rises 1 cycle after phase 3 of the last bit of a command.
  - cs_n then stays high ≥ CS_GAP cycles before the next command.
- States:
  - IDLE → WREN1 on start.
  - WREN1 (1 byte) → SE.
  - SE (4 bytes: opcode + addr[23:0]) → POLL1.
  - POLL1: send RDSR, then read status bytes continuously with cs_n low.
    - After each received byte: bit0=0 → raise cs_n, go to WREN2.
    - Otherwise, if the byte count reaches POLL_MAX → ERR.
  - WREN2 → PP.
  - PP: opcode + addr + (len+1) data bytes → POLL2.
  - POLL2: same as POLL1; exit → DONE.
  - DONE: pulse done, clear busy → IDLE.
  - ERR: raise cs_n, pulse err, clear busy → IDLE.
- Data fetch:
  - data_req pulses at phase 0 of bit 0 of the preceding byte, i.e. the last address byte or the previous data byte.
  - data_in is registered 2 cycles later into the shift register, ready for the next byte boundary.
  - Exactly len+1 data_req pulses per run.
- mosi is held 0 while reading status bytes.
- Page wrap beyond a 256-byte page is not handled; the flash wraps internally. The caller aligns addr.
- start coincident with reset release is ignored.
- start while busy is ignored with no side effect.

Optional Feature:
- FLASH_ERASE_EN
  - Defined: full sequence as above.
  - Undefined: WREN1/SE/POLL1 states are compiled out. start goes directly to WREN2 → PP → POLL2 → DONE, and the CMD_SE parameter is unused.

Test Plan:
- Full run: start, addr=24'h00_04_25, len=8'd9; flash model sets WIP=1 for 3 status bytes after SE and 2 after PP. Required:
  - mosi bytes in order: 06 | D8 00 04 25 | 05 | 06 | 02 00 04 25 + 10 data bytes | 05.
  - Exactly 10 data_req pulses.
  - done pulses once; busy low afterwards.
- Timeout: flash model holds WIP=1 forever, POLL_MAX=16'd20. Required: err pulse after 20 status bytes, cs_n=1, busy=0, no WREN2 issued.
- Boundary length:
  - len=8'd0 → 1 data byte and 1 data_req.
  - len=8'd255 → 256 data bytes and 256 data_req.
  - Data order matches data_in sequence 8'h00..8'hFF.
- Timing: between every cs_n rise and the next fall, ≥ 8 cycles high. Each byte spans 32 cycles with 8 sck rising edges.
- Reset mid-PP: assert sys_rst_n=0 during data byte 3. Required: cs_n=1, sck=0, busy=0 at once. A new start afterwards runs a clean full sequence.
- Compile without FLASH_ERASE_EN: start produces first mosi byte 06 followed by 02, with no D8 anywhere.
